// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// (port 0) and data access (port 1). One transaction is in flight at a time and
// walks IDLE -> ISSUE -> WAIT (LAT cycles) -> RESP -> IDLE. Port 1 normally wins
// arbitration, but port 0 is forced through after STARVE_MAX consecutive losses.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int LAT        = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid_i,
    input  logic [AW-1:0] req0_addr_i,
    output logic          req0_ready_o,
    input  logic          req1_valid_i,
    input  logic          req1_we_i,
    input  logic [AW-1:0] req1_addr_i,
    input  logic [DW-1:0] req1_wdata_i,
    output logic          req1_ready_o,
    output logic          resp0_valid_o,
    output logic          resp1_valid_o,
    output logic [DW-1:0] resp_rdata_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          sel_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [3:0] WAIT_LAST  = 4'(LAT - 1);

    state_e        state_q, state_d;
    logic [3:0]    waitCnt_q, waitCnt_d;
    logic [3:0]    starveCnt_q, starveCnt_d;
    logic          sel_q, sel_d;
    logic          memWe_q, memWe_d;
    logic [AW-1:0] memAddr_q, memAddr_d;
    logic [DW-1:0] memWdata_q, memWdata_d;
    logic [DW-1:0] respRdata_q, respRdata_d;
    logic          grant0, grant1;

    // State register plus the latched transaction and captured read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            waitCnt_q   <= '0;
            starveCnt_q <= '0;
            sel_q       <= 1'b0;
            memWe_q     <= 1'b0;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
            respRdata_q <= '0;
        end else begin
            state_q     <= state_d;
            waitCnt_q   <= waitCnt_d;
            starveCnt_q <= starveCnt_d;
            sel_q       <= sel_d;
            memWe_q     <= memWe_d;
            memAddr_q   <= memAddr_d;
            memWdata_q  <= memWdata_d;
            respRdata_q <= respRdata_d;
        end
    end

    // Arbitration in IDLE, latency counting in WAIT, and next-state selection.
    always_comb begin
        state_d     = state_q;
        waitCnt_d   = waitCnt_q;
        starveCnt_d = starveCnt_q;
        sel_d       = sel_q;
        memWe_d     = memWe_q;
        memAddr_d   = memAddr_q;
        memWdata_d  = memWdata_q;
        respRdata_d = respRdata_q;
        grant0      = 1'b0;
        grant1      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req1_valid_i && !(req0_valid_i && (starveCnt_q == STARVE_LIM))) begin
                    grant1 = 1'b1;
                end else if (req0_valid_i) begin
                    grant0 = 1'b1;
                end

                if (req0_valid_i || req1_valid_i) begin
                    if (req0_valid_i && grant1) begin
                        starveCnt_d = (starveCnt_q == STARVE_LIM) ? STARVE_LIM
                                                                  : starveCnt_q + 4'd1;
                    end else begin
                        starveCnt_d = '0;
                    end
                end

                if (grant1) begin
                    sel_d      = 1'b1;
                    memWe_d    = req1_we_i;
                    memAddr_d  = req1_addr_i;
                    memWdata_d = req1_wdata_i;
                    state_d    = ISSUE;
                end else if (grant0) begin
                    sel_d     = 1'b0;
                    memWe_d   = 1'b0;
                    memAddr_d = req0_addr_i;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                waitCnt_d = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                if (waitCnt_q == WAIT_LAST) begin
                    respRdata_d = memWe_q ? '0 : mem_rdata_i;
                    state_d     = RESP;
                end else begin
                    waitCnt_d = waitCnt_q + 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Readies are gated by reset so nothing is granted while the block is held in reset.
    assign req0_ready_o  = rst_n & grant0;
    assign req1_ready_o  = rst_n & grant1;
    assign mem_en_o      = (state_q == ISSUE);
    assign mem_we_o      = (state_q == ISSUE) & memWe_q;
    assign mem_addr_o    = memAddr_q;
    assign mem_wdata_o   = memWdata_q;
    assign resp0_valid_o = (state_q == RESP) & ~sel_q;
    assign resp1_valid_o = (state_q == RESP) & sel_q;
    assign resp_rdata_o  = respRdata_q;
    assign sel_o         = sel_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter. Instance A runs with
// LAT=1 for the arbitration table and reset cases; instance B runs with LAT=4 for
// back-to-back throughput. A small latency-accurate memory model feeds each one.
module tb_mem_port_arbiter;

    localparam int LAT_A = 1;
    localparam int LAT_B = 4;
    localparam logic [31:0] GARBAGE = 32'hBAD0BAD0;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic [31:0] req0_addr;
    logic        req1_valid;
    logic        req1_we;
    logic [31:0] req1_addr;
    logic [31:0] req1_wdata;

    logic        aReq0Ready, aReq1Ready, aResp0Valid, aResp1Valid, aMemEn, aMemWe, aSel;
    logic [31:0] aRespRdata, aMemAddr, aMemWdata, aMemRdata;
    logic        bReq0Ready, bReq1Ready, bResp0Valid, bResp1Valid, bMemEn, bMemWe, bSel;
    logic [31:0] bRespRdata, bMemAddr, bMemWdata, bMemRdata;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        v0;
        logic        v1;
        logic        we;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic [31:0] wdata;
        logic        pulse1;
        logic        expGrant;
        logic        expWe;
        logic [31:0] expAddr;
        logic [31:0] expRdata;
    } vec_t;

    vec_t vecs [16];

    mem_port_arbiter #(.AW(32), .DW(32), .LAT(LAT_A), .STARVE_MAX(3)) dutA (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(req0_valid), .req0_addr_i(req0_addr), .req0_ready_o(aReq0Ready),
        .req1_valid_i(req1_valid), .req1_we_i(req1_we), .req1_addr_i(req1_addr),
        .req1_wdata_i(req1_wdata), .req1_ready_o(aReq1Ready),
        .resp0_valid_o(aResp0Valid), .resp1_valid_o(aResp1Valid), .resp_rdata_o(aRespRdata),
        .mem_en_o(aMemEn), .mem_we_o(aMemWe), .mem_addr_o(aMemAddr),
        .mem_wdata_o(aMemWdata), .mem_rdata_i(aMemRdata), .sel_o(aSel)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .LAT(LAT_B), .STARVE_MAX(3)) dutB (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(req0_valid), .req0_addr_i(req0_addr), .req0_ready_o(bReq0Ready),
        .req1_valid_i(req1_valid), .req1_we_i(req1_we), .req1_addr_i(req1_addr),
        .req1_wdata_i(req1_wdata), .req1_ready_o(bReq1Ready),
        .resp0_valid_o(bResp0Valid), .resp1_valid_o(bResp1Valid), .resp_rdata_o(bRespRdata),
        .mem_en_o(bMemEn), .mem_we_o(bMemWe), .mem_addr_o(bMemAddr),
        .mem_wdata_o(bMemWdata), .mem_rdata_i(bMemRdata), .sel_o(bSel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a fixed word at 0x10, otherwise the address and its inverse.
    function automatic logic [31:0] dataOf(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    logic [31:0] pipeA [LAT_A];
    logic [31:0] pipeB [LAT_B];

    // Memory models: read data appears exactly LAT cycles after mem_en, garbage otherwise.
    always @(posedge clk) begin
        pipeA[0] <= (aMemEn && !aMemWe) ? dataOf(aMemAddr) : GARBAGE;
        for (int i = 1; i < LAT_A; i++) pipeA[i] <= pipeA[i-1];
        pipeB[0] <= (bMemEn && !bMemWe) ? dataOf(bMemAddr) : GARBAGE;
        for (int i = 1; i < LAT_B; i++) pipeB[i] <= pipeB[i-1];
    end
    assign aMemRdata = pipeA[LAT_A-1];
    assign bMemRdata = pipeB[LAT_B-1];

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Runs one full transaction on instance A and checks every phase of it.
    task automatic applyStimulus(input vec_t v, input int idx);
        @(posedge clk); #1;
        req0_valid = v.v0;
        req0_addr  = v.addr0;
        req1_valid = v.v1;
        req1_we    = v.we;
        req1_addr  = v.addr1;
        req1_wdata = v.wdata;
        #1;
        checkOutput($sformatf("v%0d ready0", idx), 32'(aReq0Ready), 32'(!v.expGrant));
        checkOutput($sformatf("v%0d ready1", idx), 32'(aReq1Ready), 32'(v.expGrant));

        @(posedge clk); #1;
        if (v.expGrant) req1_valid = 1'b0;
        else            req0_valid = 1'b0;
        #1;
        checkOutput($sformatf("v%0d mem_en", idx), 32'(aMemEn), 32'd1);
        checkOutput($sformatf("v%0d mem_we", idx), 32'(aMemWe), 32'(v.expWe));
        checkOutput($sformatf("v%0d mem_addr", idx), aMemAddr, v.expAddr);
        checkOutput($sformatf("v%0d sel", idx), 32'(aSel), 32'(v.expGrant));
        checkOutput($sformatf("v%0d busy readies", idx), 32'({aReq0Ready, aReq1Ready}), 32'd0);
        if (v.expGrant) checkOutput($sformatf("v%0d mem_wdata", idx), aMemWdata, v.wdata);

        for (int k = 0; k < LAT_A; k++) begin
            @(posedge clk); #1;
            if (v.pulse1 && k == 0) req1_valid = 1'b1;
            #1;
            checkOutput($sformatf("v%0d wait%0d mem_en", idx, k), 32'(aMemEn), 32'd0);
            checkOutput($sformatf("v%0d wait%0d readies", idx, k),
                        32'({aReq0Ready, aReq1Ready}), 32'd0);
            checkOutput($sformatf("v%0d wait%0d resp", idx, k),
                        32'({aResp0Valid, aResp1Valid}), 32'd0);
        end

        @(posedge clk); #1;
        if (v.pulse1) req1_valid = 1'b0;
        #1;
        checkOutput($sformatf("v%0d resp valids", idx), 32'({aResp0Valid, aResp1Valid}),
                    v.expGrant ? 32'd1 : 32'd2);
        checkOutput($sformatf("v%0d resp_rdata", idx), aRespRdata, v.expRdata);
        checkOutput($sformatf("v%0d resp mem_en", idx), 32'(aMemEn), 32'd0);
    endtask

    function automatic vec_t mk(input logic v0, input logic v1, input logic we,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] wd, input logic pulse,
                                input logic g, input logic eWe,
                                input logic [31:0] eAddr, input logic [31:0] eRd);
        vec_t r;
        r.v0 = v0; r.v1 = v1; r.we = we; r.addr0 = a0; r.addr1 = a1; r.wdata = wd;
        r.pulse1 = pulse; r.expGrant = g; r.expWe = eWe; r.expAddr = eAddr; r.expRdata = eRd;
        return r;
    endfunction

    int accepts [$];
    int resps   [$];

    initial begin
        //            v0 v1 we addr0      addr1      wdata      p  g  we expAddr    expRdata
        vecs[0]  = mk(1, 0, 0, 32'h10,  32'h0,   32'h0,    0, 0, 0, 32'h10,  32'hDEADBEEF);
        vecs[1]  = mk(0, 1, 1, 32'h0,   32'h40,  32'h1234, 0, 1, 1, 32'h40,  32'h0);
        vecs[2]  = mk(0, 1, 0, 32'h0,   32'h80,  32'h0,    0, 1, 0, 32'h80,  32'h0080FF7F);
        vecs[3]  = mk(1, 1, 0, 32'h104, 32'h204, 32'h0,    0, 1, 0, 32'h204, 32'h0204FDFB);
        vecs[4]  = mk(1, 1, 1, 32'h108, 32'h208, 32'hA5A5, 0, 1, 1, 32'h208, 32'h0);
        vecs[5]  = mk(1, 1, 0, 32'h10C, 32'h20C, 32'h0,    0, 1, 0, 32'h20C, 32'h020CFDF3);
        vecs[6]  = mk(1, 1, 0, 32'h110, 32'h210, 32'h0,    0, 0, 0, 32'h110, 32'h0110FEEF);
        vecs[7]  = mk(1, 1, 1, 32'h114, 32'h214, 32'hBEEF, 0, 1, 1, 32'h214, 32'h0);
        vecs[8]  = mk(1, 1, 0, 32'h118, 32'h218, 32'h0,    0, 1, 0, 32'h218, 32'h0218FDE7);
        vecs[9]  = mk(1, 1, 0, 32'h11C, 32'h21C, 32'h0,    0, 1, 0, 32'h21C, 32'h021CFDE3);
        vecs[10] = mk(1, 1, 1, 32'h120, 32'h220, 32'h7777, 0, 0, 0, 32'h120, 32'h0120FEDF);
        vecs[11] = mk(1, 0, 0, 32'h10,  32'h0,   32'h0,    0, 0, 0, 32'h10,  32'hDEADBEEF);
        vecs[12] = mk(1, 1, 0, 32'h130, 32'h230, 32'h0,    0, 1, 0, 32'h230, 32'h0230FDCF);
        vecs[13] = mk(1, 1, 0, 32'h134, 32'h234, 32'h0,    1, 1, 0, 32'h234, 32'h0234FDCB);
        vecs[14] = mk(1, 1, 0, 32'h138, 32'h238, 32'h0,    0, 1, 0, 32'h238, 32'h0238FDC7);
        vecs[15] = mk(1, 1, 1, 32'h13C, 32'h23C, 32'h1,    0, 0, 0, 32'h13C, 32'h013CFEC3);

        rst_n = 1'b0;
        req0_valid = 1'b1; req0_addr = 32'h10;
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 32'h40; req1_wdata = 32'h55;

        // Held in reset with requests pending: every output must stay at zero.
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset readies A", 32'({aReq0Ready, aReq1Ready}), 32'd0);
        checkOutput("reset resp A", 32'({aResp0Valid, aResp1Valid}), 32'd0);
        checkOutput("reset rdata A", aRespRdata, 32'd0);
        checkOutput("reset mem_en/we A", 32'({aMemEn, aMemWe}), 32'd0);
        checkOutput("reset mem_addr A", aMemAddr, 32'd0);
        checkOutput("reset mem_wdata A", aMemWdata, 32'd0);
        checkOutput("reset sel A", 32'(aSel), 32'd0);
        checkOutput("reset readies B", 32'({bReq0Ready, bReq1Ready, bMemEn}), 32'd0);

        @(posedge clk); #1;
        rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;

        for (int i = 0; i <= 10; i++) applyStimulus(vecs[i], i);

        // Load interrupted by reset in its WAIT cycle.
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h80;
        #1;
        checkOutput("rstwait ready1", 32'(aReq1Ready), 32'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        #1;
        checkOutput("rstwait mem_en", 32'(aMemEn), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0; req0_valid = 1'b1;
        #1;
        checkOutput("rstwait rdata", aRespRdata, 32'd0);
        checkOutput("rstwait mem_addr", aMemAddr, 32'd0);
        checkOutput("rstwait sel/en", 32'({aSel, aMemEn, aReq0Ready}), 32'd0);
        @(posedge clk); #1;
        checkOutput("rstwait resp", 32'({aResp0Valid, aResp1Valid}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; req0_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput($sformatf("post-reset idle%0d", k),
                        32'({aMemEn, aResp0Valid, aResp1Valid, aReq0Ready, aReq1Ready}), 32'd0);
            @(posedge clk); #1;
        end

        for (int i = 11; i <= 15; i++) applyStimulus(vecs[i], i);

        // Back-to-back fetches on the LAT=4 instance.
        @(posedge clk); #1;
        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; req0_valid = 1'b1; req0_addr = 32'h10;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (bReq0Ready) accepts.push_back(cyc);
            if (bResp0Valid) begin
                resps.push_back(cyc);
                checkOutput($sformatf("b2b rdata c%0d", cyc), bRespRdata, 32'hDEADBEEF);
            end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        if (accepts.size() < 3 || resps.size() < 3) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL b2b count: got %0d accepts %0d resps expected >=3 each",
                     accepts.size(), resps.size());
        end else begin
            checkOutput("b2b accept gap 1", 32'(accepts[1] - accepts[0]), 32'd7);
            checkOutput("b2b accept gap 2", 32'(accepts[2] - accepts[1]), 32'd7);
            for (int i = 0; i < 3; i++)
                checkOutput($sformatf("b2b resp lag %0d", i), 32'(resps[i] - accepts[i]), 32'd6);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
